// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared types and constants for the pipelined ARM CPU front end.
//   br_kind_t : redirect kinds reported by the branch-resolve stage
//               (2'b11 is reserved and never names a real redirect).
//   NOP_INST  : encoding placed in IF/ID as a bubble.
//   RESET_PC  : PC loaded on reset.
package cpu_pkg;

  typedef enum logic [1:0] {
    BR_COND   = 2'b00,
    BR_UNCOND = 2'b01,
    BR_REG    = 2'b10
  } br_kind_t;

  localparam logic [31:0] NOP_INST = 32'hD503_201F;
  localparam logic [63:0] RESET_PC = 64'h0;

  // True when the raw 2-bit kind names a defined redirect kind.
  function automatic logic kind_is_defined(input logic [1:0] kind);
    return (kind != 2'b11);
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// branch_target_calc
//   Combinational redirect-target computation for the fetch stage.
//   Ports:
//     i_kind        in  2       raw redirect kind (br_kind_t encoding, 2'b11 reserved)
//     i_branch_pc   in  ADDR_W  PC of the redirecting branch
//     i_cond_addr19 in  19      CB-type signed word offset
//     i_br_addr26   in  26      B-type signed word offset
//     i_reg_target  in  ADDR_W  BR register value
//     o_target      out ADDR_W  computed target (modulo 2^ADDR_W)
//     o_kind_ok     out 1       1 when i_kind is a defined redirect kind
module branch_target_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [1:0]        i_kind,
  input  logic [ADDR_W-1:0] i_branch_pc,
  input  logic [18:0]       i_cond_addr19,
  input  logic [25:0]       i_br_addr26,
  input  logic [ADDR_W-1:0] i_reg_target,
  output logic [ADDR_W-1:0] o_target,
  output logic              o_kind_ok
);

  // Word-aligned register targets: clear the two low bits.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

  logic [ADDR_W-1:0] w_se19;
  logic [ADDR_W-1:0] w_se26;

  // Sign-extend the word offsets to full address width.
  assign w_se19 = {{(ADDR_W-19){i_cond_addr19[18]}}, i_cond_addr19};
  assign w_se26 = {{(ADDR_W-26){i_br_addr26[25]}}, i_br_addr26};

  // Select the target by redirect kind; reserved kind yields no valid target.
  always_comb begin
    o_target  = i_branch_pc;
    o_kind_ok = kind_is_defined(i_kind);
    case (br_kind_t'(i_kind))
      BR_COND:   o_target = i_branch_pc + (w_se19 << 2);
      BR_UNCOND: o_target = i_branch_pc + (w_se26 << 2);
      BR_REG:    o_target = i_reg_target & ALIGN_MASK;
      default:   o_target = i_branch_pc;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   IF stage: owns the PC, drives the instruction-memory address, applies
//   redirects from branch resolution and stalls from the hazard unit, and
//   registers the fetched instruction into the IF/ID pipeline register.
//   Ports:
//     clk, rst        clock (rising edge), asynchronous active-high reset
//     imem_addr       out ADDR_W  instruction address (= current PC)
//     imem_data       in  INST_W  instruction at imem_addr (same cycle)
//     stall           in  1       hold PC and IF/ID
//     redirect        in  1       taken branch resolved this cycle
//     redirect_kind   in  2       COND / UNCOND / REG (2'b11 ignored)
//     branch_pc       in  ADDR_W  PC of the redirecting branch
//     condAddr19      in  19      CB-type word offset
//     brAddr26        in  26      B-type word offset
//     reg_target      in  ADDR_W  BR register value
//     if_id_inst      out INST_W  registered instruction
//     if_id_pc        out ADDR_W  PC of if_id_inst
//     if_id_pc_plus4  out ADDR_W  if_id_pc + 4 (link value)
//     if_id_valid     out 1       1 = real instruction, 0 = bubble
//     fetch_count     out 32      valid instructions loaded into IF/ID
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC),
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(cpu_pkg::NOP_INST)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [1:0]        redirect_kind,
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic [18:0]       condAddr19,
  input  logic [25:0]       brAddr26,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [INST_W-1:0] if_id_inst,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_pc_plus4,
  output logic              if_id_valid,
  output logic [31:0]       fetch_count
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_if_pc;
  logic [ADDR_W-1:0] r_if_pc_plus4;
  logic              r_valid;
  logic [31:0]       r_count;

  logic [ADDR_W-1:0] w_target;
  logic              w_kind_ok;
  logic              w_take_redirect;
  logic [ADDR_W-1:0] w_pc_next_seq;

  branch_target_calc #(
    .ADDR_W (ADDR_W)
  ) u_target (
    .i_kind        (redirect_kind),
    .i_branch_pc   (branch_pc),
    .i_cond_addr19 (condAddr19),
    .i_br_addr26   (brAddr26),
    .i_reg_target  (reg_target),
    .o_target      (w_target),
    .o_kind_ok     (w_kind_ok)
  );

  // A reserved kind must behave exactly as if no redirect were requested.
  assign w_take_redirect = redirect & w_kind_ok;
  assign w_pc_next_seq   = r_pc + PC_STEP;

  // PC, IF/ID and fetch counter: redirect beats stall beats sequential fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inst        <= NOP_INST;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
      r_valid       <= 1'b0;
      r_count       <= 32'd0;
    end else if (w_take_redirect) begin
      // Bubble the wrong-path instruction; PC fields keep their old values.
      r_pc    <= w_target;
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end else if (stall) begin
      r_pc    <= r_pc;
      r_valid <= r_valid;
    end else begin
      r_pc          <= w_pc_next_seq;
      r_inst        <= imem_data;
      r_if_pc       <= r_pc;
      r_if_pc_plus4 <= w_pc_next_seq;
      r_valid       <= 1'b1;
      r_count       <= r_count + 32'd1;
    end
  end

  assign imem_addr      = r_pc;
  assign if_id_inst     = r_inst;
  assign if_id_pc       = r_if_pc;
  assign if_id_pc_plus4 = r_if_pc_plus4;
  assign if_id_valid    = r_valid;
  assign fetch_count    = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Self-checking bench for fetch_stage: a directed vector table, hand-written
//   reset/wrap sequences, and randomized stimulus against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hD503_201F;

  logic        clk;
  logic        rst;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [1:0]  redirect_kind;
  logic [63:0] branch_pc;
  logic [18:0] condAddr19;
  logic [25:0] brAddr26;
  logic [63:0] reg_target;
  logic [31:0] if_id_inst;
  logic [63:0] if_id_pc;
  logic [63:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int n_vec = 0;
  int n_err = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_kind  (redirect_kind),
    .branch_pc      (branch_pc),
    .condAddr19     (condAddr19),
    .brAddr26       (brAddr26),
    .reg_target     (reg_target),
    .if_id_inst     (if_id_inst),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .fetch_count    (fetch_count)
  );

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_at(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hE1A0_0000;
  endfunction

  assign imem_data = mem_at(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic [1:0] kind, input logic st,
                       input logic [63:0] bpc, input logic [18:0] c19,
                       input logic [25:0] b26, input logic [63:0] rt);
    redirect      = rd;
    redirect_kind = kind;
    stall         = st;
    branch_pc     = bpc;
    condAddr19    = c19;
    brAddr26      = b26;
    reg_target    = rt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model state
  logic [63:0] m_pc, m_ifpc, m_p4;
  logic [31:0] m_inst, m_cnt;
  logic        m_valid;

  function automatic logic [63:0] model_target(input logic [1:0] kind, input logic [63:0] bpc,
                                               input logic [18:0] c19, input logic [25:0] b26,
                                               input logic [63:0] rt);
    longint off;
    if (kind == 2'b00) begin
      off = longint'($signed(c19));
      return bpc + 64'(off * 4);
    end else if (kind == 2'b01) begin
      off = longint'($signed(b26));
      return bpc + 64'(off * 4);
    end else begin
      return rt - (rt % 64'd4);
    end
  endfunction

  task automatic model_reset();
    m_pc = 64'h0; m_ifpc = 64'h0; m_p4 = 64'h0;
    m_inst = NOP; m_cnt = 32'd0; m_valid = 1'b0;
  endtask

  task automatic model_edge();
    if (redirect && redirect_kind != 2'b11) begin
      m_pc    = model_target(redirect_kind, branch_pc, condAddr19, brAddr26, reg_target);
      m_inst  = NOP;
      m_valid = 1'b0;
    end else if (!stall) begin
      m_inst  = mem_at(m_pc);
      m_ifpc  = m_pc;
      m_p4    = m_pc + 64'd4;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
      m_pc    = m_pc + 64'd4;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},    imem_addr,      m_pc);
    check({tag, ".inst"},  64'(if_id_inst), 64'(m_inst));
    check({tag, ".ifpc"},  if_id_pc,       m_ifpc);
    check({tag, ".p4"},    if_id_pc_plus4, m_p4);
    check({tag, ".valid"}, 64'(if_id_valid), 64'(m_valid));
    check({tag, ".cnt"},   64'(fetch_count), 64'(m_cnt));
  endtask

  typedef struct {
    logic        rd;
    logic [1:0]  kind;
    logic        st;
    logic [63:0] bpc;
    logic [18:0] c19;
    logic [25:0] b26;
    logic [63:0] rt;
    logic [63:0] e_pc;
    logic        e_valid;
    logic [63:0] e_ifpc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b0, 2'b00, 1'b0, 64'h0,   19'd0, 26'd0,         64'h0,    64'h4,    1'b1, 64'h0,    32'd1};
    tbl[1]  = '{1'b0, 2'b00, 1'b0, 64'h0,   19'd0, 26'd0,         64'h0,    64'h8,    1'b1, 64'h4,    32'd2};
    tbl[2]  = '{1'b0, 2'b00, 1'b0, 64'h0,   19'd0, 26'd0,         64'h0,    64'hC,    1'b1, 64'h8,    32'd3};
    tbl[3]  = '{1'b1, 2'b01, 1'b0, 64'h20,  19'd0, 26'h3FF_FFFE,  64'h0,    64'h18,   1'b0, 64'h8,    32'd3};
    tbl[4]  = '{1'b0, 2'b00, 1'b0, 64'h0,   19'd0, 26'd0,         64'h0,    64'h1C,   1'b1, 64'h18,   32'd4};
    tbl[5]  = '{1'b1, 2'b00, 1'b0, 64'h40,  19'd3, 26'd0,         64'h0,    64'h4C,   1'b0, 64'h18,   32'd4};
    tbl[6]  = '{1'b1, 2'b10, 1'b0, 64'h0,   19'd0, 26'd0,         64'h1003, 64'h1000, 1'b0, 64'h18,   32'd4};
    tbl[7]  = '{1'b0, 2'b00, 1'b0, 64'h0,   19'd0, 26'd0,         64'h0,    64'h1004, 1'b1, 64'h1000, 32'd5};
    tbl[8]  = '{1'b0, 2'b00, 1'b1, 64'h0,   19'd0, 26'd0,         64'h0,    64'h1004, 1'b1, 64'h1000, 32'd5};
    tbl[9]  = '{1'b0, 2'b00, 1'b1, 64'h0,   19'd0, 26'd0,         64'h0,    64'h1004, 1'b1, 64'h1000, 32'd5};
    tbl[10] = '{1'b1, 2'b01, 1'b1, 64'h100, 19'd0, 26'd1,         64'h0,    64'h104,  1'b0, 64'h1000, 32'd5};
    tbl[11] = '{1'b1, 2'b11, 1'b0, 64'h500, 19'd7, 26'd7,         64'h777,  64'h108,  1'b1, 64'h104,  32'd6};
    tbl[12] = '{1'b0, 2'b00, 1'b0, 64'h0,   19'd0, 26'd0,         64'h0,    64'h10C,  1'b1, 64'h108,  32'd7};
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 64'h0, 19'd0, 26'd0, 64'h0);
    #12;
    check("rst.pc",    imem_addr, 64'h0);
    check("rst.inst",  64'(if_id_inst), 64'(NOP));
    check("rst.valid", 64'(if_id_valid), 64'h0);
    check("rst.cnt",   64'(fetch_count), 64'h0);
    check("rst.p4",    if_id_pc_plus4, 64'h0);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rd, tbl[i].kind, tbl[i].st, tbl[i].bpc, tbl[i].c19, tbl[i].b26, tbl[i].rt);
      step();
      check($sformatf("tbl%0d.pc", i),    imem_addr, tbl[i].e_pc);
      check($sformatf("tbl%0d.valid", i), 64'(if_id_valid), 64'(tbl[i].e_valid));
      check($sformatf("tbl%0d.ifpc", i),  if_id_pc, tbl[i].e_ifpc);
      check($sformatf("tbl%0d.p4", i),    if_id_pc_plus4, tbl[i].e_ifpc + 64'd4);
      check($sformatf("tbl%0d.inst", i),  64'(if_id_inst),
            64'(tbl[i].e_valid ? mem_at(tbl[i].e_ifpc) : NOP));
      check($sformatf("tbl%0d.cnt", i),   64'(fetch_count), 64'(tbl[i].e_cnt));
    end

    // PC wrap: jump to the top word, then fetch sequentially across zero
    drive(1'b1, 2'b10, 1'b0, 64'h0, 19'd0, 26'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("wrap.tgt", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(1'b0, 2'b00, 1'b0, 64'h0, 19'd0, 26'd0, 64'h0);
    step();
    check("wrap.pc",   imem_addr, 64'h0);
    check("wrap.ifpc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap.p4",   if_id_pc_plus4, 64'h0);
    check("wrap.inst", 64'(if_id_inst), 64'(mem_at(64'hFFFF_FFFF_FFFF_FFFC)));

    // Asynchronous reset mid-run while a redirect is being presented
    drive(1'b1, 2'b01, 1'b0, 64'h300, 19'd0, 26'd5, 64'h0);
    #2;
    rst = 1'b1;
    #1;
    check("arst.pc",    imem_addr, 64'h0);
    check("arst.valid", 64'(if_id_valid), 64'h0);
    check("arst.inst",  64'(if_id_inst), 64'(NOP));
    check("arst.cnt",   64'(fetch_count), 64'h0);
    check("arst.ifpc",  if_id_pc, 64'h0);
    step();
    check("arst.hold",  imem_addr, 64'h0);
    drive(1'b0, 2'b00, 1'b0, 64'h0, 19'd0, 26'd0, 64'h0);
    #2;
    rst = 1'b0;
    model_reset();

    // Randomized stimulus against the behavioural model
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
            {$urandom, $urandom}, 19'($urandom), 26'($urandom), {$urandom, $urandom});
      model_edge();
      step();
      check_model($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
